// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer, flush and an EX/MEM
// forwarding port. The head entry drives out_* and the skid entry absorbs a
// single-cycle backpressure bubble so in_ready comes straight from a flop.
// Optional feature macro: EX_MEM_OVF_TRAP_EN (signed-overflow trap capture).
module ex_mem_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [WIDTH-1:0] in_store_data,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_regwrite,
  input  logic             in_memread,
  input  logic             in_memwrite,
  input  logic             in_ovf,
  input  logic             in_ovf_trap,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [WIDTH-1:0] out_pc,
  output logic [RA_W-1:0]  out_rd,
  output logic             out_regwrite,
  output logic             out_memread,
  output logic             out_memwrite,
  output logic             fwd_valid,
  output logic [RA_W-1:0]  fwd_rd,
  output logic [WIDTH-1:0] fwd_result,
  output logic             out_exc
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] store_data;
    logic [WIDTH-1:0] pc;
    logic [RA_W-1:0]  rd;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
`ifdef EX_MEM_OVF_TRAP_EN
    logic             exc;
`endif
  } entry_t;

  entry_t head_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   head_valid;
  logic   skid_valid;
  logic   accept;
  logic   retire;

  assign accept = in_valid && in_ready;
  assign retire = head_valid && out_ready;

  // Pack the incoming instruction; a trapping overflow loses its side effects.
  always_comb begin
    in_entry            = '0;
    in_entry.result     = in_result;
    in_entry.store_data = in_store_data;
    in_entry.pc         = in_pc;
    in_entry.rd         = in_rd;
    in_entry.regwrite   = in_regwrite;
    in_entry.memread    = in_memread;
    in_entry.memwrite   = in_memwrite;
`ifdef EX_MEM_OVF_TRAP_EN
    in_entry.exc        = in_ovf && in_ovf_trap;
    if (in_ovf && in_ovf_trap) begin
      in_entry.regwrite = 1'b0;
      in_entry.memread  = 1'b0;
      in_entry.memwrite = 1'b0;
    end
`endif
  end

`ifndef EX_MEM_OVF_TRAP_EN
  // Overflow inputs have no effect when the trap is not built.
  logic unused_ovf;
  assign unused_ovf = in_ovf ^ in_ovf_trap;
`endif

  // Head/skid occupancy and data movement; head always holds the oldest entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!head_valid) begin
      if (accept) begin
        head_q     <= in_entry;
        head_valid <= 1'b1;
      end
    end else if (retire) begin
      if (skid_valid) begin
        head_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        head_q <= in_entry;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready       = !skid_valid;
  assign out_valid      = head_valid;
  assign out_result     = head_q.result;
  assign out_store_data = head_q.store_data;
  assign out_pc         = head_q.pc;
  assign out_rd         = head_q.rd;
  assign out_regwrite   = head_valid && head_q.regwrite;
  assign out_memread    = head_valid && head_q.memread;
  assign out_memwrite   = head_valid && head_q.memwrite;

  // Loads are not forwardable from here (data not yet read); r0 never is.
  assign fwd_valid  = out_regwrite && !out_memread && (head_q.rd != '0);
  assign fwd_rd     = head_q.rd;
  assign fwd_result = head_q.result;

`ifdef EX_MEM_OVF_TRAP_EN
  assign out_exc = head_valid && head_q.exc;
`else
  assign out_exc = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the stage is modelled as an ordered
// queue holding at most two instructions; stimulus pushes accepted entries,
// a negedge monitor pops on retire and compares every visible output.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_result, in_store_data, in_pc;
  logic [4:0]  in_rd;
  logic        in_regwrite, in_memread, in_memwrite, in_ovf, in_ovf_trap;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data, out_pc;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_memread, out_memwrite;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_result;
  logic        out_exc;

  ex_mem_stage #(.WIDTH(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_store_data(in_store_data), .in_pc(in_pc),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_ovf(in_ovf), .in_ovf_trap(in_ovf_trap),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_pc(out_pc),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_memwrite(out_memwrite), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_result(fwd_result), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result, store_data, pc;
    logic [4:0]  rd;
    bit          regwrite, memread, memwrite, exc;
  } exp_t;

  exp_t q[$];
  int   held_cnt = 0;
  bit   mon_en   = 1'b0;
  int   tests    = 0;
  int   fails    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the expected entry is queued when the model says it is taken.
  task automatic drive(input bit iv, input logic [31:0] res, input logic [31:0] st,
                       input logic [31:0] pc, input logic [4:0] rd, input bit rw,
                       input bit mr, input bit mw, input bit ovf, input bit trap,
                       input bit ordy, input bit fl);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = iv; in_result = res; in_store_data = st; in_pc = pc; in_rd = rd;
    in_regwrite = rw; in_memread = mr; in_memwrite = mw;
    in_ovf = ovf; in_ovf_trap = trap; out_ready = ordy; flush = fl;
    held_cnt = q.size();
    if (iv && !fl && q.size() < 2) begin
      e.result = res; e.store_data = st; e.pc = pc; e.rd = rd;
`ifdef EX_MEM_OVF_TRAP_EN
      e.exc = ovf && trap;
`else
      e.exc = 1'b0;
`endif
      e.regwrite = rw && !e.exc;
      e.memread  = mr && !e.exc;
      e.memwrite = mw && !e.exc;
      q.push_back(e);
    end
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic send(input logic [31:0] res, input logic [4:0] rd, input bit ordy);
    drive(1'b1, res, ~res, 32'h0040_0000 + res, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: compare the head against the oldest model entry, retire it, apply flush.
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, held_cnt < 2});
        chk("out_valid", {31'b0, out_valid}, {31'b0, held_cnt > 0});
        if (held_cnt > 0) begin
          h = q[0];
          chk("out_result", out_result, h.result);
          chk("out_store_data", out_store_data, h.store_data);
          chk("out_pc", out_pc, h.pc);
          chk("out_rd", {27'b0, out_rd}, {27'b0, h.rd});
          chk("out_ctrl", {29'b0, out_regwrite, out_memread, out_memwrite},
              {29'b0, h.regwrite, h.memread, h.memwrite});
          chk("out_exc", {31'b0, out_exc}, {31'b0, h.exc});
          chk("fwd_valid", {31'b0, fwd_valid},
              {31'b0, h.regwrite && !h.memread && h.rd != 5'd0});
          if (h.regwrite && !h.memread && h.rd != 5'd0) begin
            chk("fwd_rd", {27'b0, fwd_rd}, {27'b0, h.rd});
            chk("fwd_result", fwd_result, h.result);
          end
          if (out_ready) void'(q.pop_front());
        end else begin
          chk("idle_ctrl", {28'b0, out_regwrite, out_memread, out_memwrite, fwd_valid}, 32'h0);
          chk("idle_exc", {31'b0, out_exc}, 32'h0);
        end
        if (flush) q.delete();
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_result = '0; in_store_data = '0; in_pc = '0;
    in_rd = '0; in_regwrite = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0;
    in_ovf = 1'b0; in_ovf_trap = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_result", out_result, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_rd", {27'b0, out_rd}, 32'h0);
    mon_en = 1'b1;

    // Single forwardable instruction
    drive(1'b1, 32'h0000_00F0, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill head and skid under backpressure, try a third, then drain in order
    send(32'h11, 5'd3, 1'b0);
    send(32'h22, 5'd4, 1'b0);
    send(32'h33, 5'd5, 1'b0);
    idle(1'b0);
    repeat (3) idle(1'b1);

    // Back-to-back stream at full throughput
    for (int i = 1; i <= 8; i++) send(i, 5'(i + 9), 1'b1);
    repeat (2) idle(1'b1);

    // Flush with both entries full and an incoming instruction
    send(32'hA1, 5'd6, 1'b0);
    send(32'hB2, 5'd7, 1'b0);
    drive(1'b1, 32'hC3, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Non-forwardable: writes to r0, and a load
    drive(1'b1, 32'h55, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h66, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // Trapping overflow
    drive(1'b1, 32'h7FFF_FFFF, 32'h0, 32'h0040_0010, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 4) < 3, $urandom_range(0, 19) == 0);
    end

    repeat (4) idle(1'b1);
    @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU/shifter in the EX stage.
- Registers the ALU result (shift, arith, logic), destination register and memory controls, and presents them to the MEM stage.
- Uses a 2-entry skid buffer with valid/ready handshake, supports pipeline flush, and provides an EX/MEM forwarding port back to the operand muxes.

Parameters:
- WIDTH, 32, datapath width of result, store data and PC.
- RA_W, 5, register-file address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  EX stage presents an instruction.
- in_ready  output  1  stage can accept; equals NOT skid_valid (registered source only).
- in_result  input  WIDTH  ALU/shifter output S.
- in_store_data  input  WIDTH  rt value for stores.
- in_pc  input  WIDTH  instruction PC.
- in_rd  input  RA_W  destination register.
- in_regwrite  input  1  writes the register file.
- in_memread  input  1  load.
- in_memwrite  input  1  store.
- in_ovf  input  1  ALU signed-overflow flag.
- in_ovf_trap  input  1  instruction traps on overflow (add/sub, not addu/subu).
- flush  input  1  kill all held and incoming instructions.
- out_valid  output  1  head entry valid.
- out_ready  input  1  MEM stage accepts.
- out_result, out_store_data, out_pc  output  WIDTH  head entry fields.
- out_rd  output  RA_W  head entry field.
- out_regwrite, out_memread, out_memwrite  output  1  head entry fields.
- fwd_valid  output  1  head entry is forwardable.
- fwd_rd  output  RA_W  forwarded destination.
- fwd_result  output  WIDTH  forwarded value.
- out_exc  output  1  overflow exception (feature only; tied 0 otherwise).

Behaviour:
- Storage: head register (drives out_*) and skid register. Each has a valid bit. The head always holds the oldest entry.
- Accept event: in_valid && in_ready. Retire event: out_valid && out_ready.
- Reset (reset==0 at a clk edge): both valid bits 0 and all data/control registers 0. So in_ready=1, out_valid=0, fwd_valid=0, out_exc=0.
- Transitions at each clk edge, with flush==0 and reset==1:
  - Head empty, accept: input loads head.
  - Head full, no retire, accept: input loads skid. in_ready goes 0 the next cycle.
  - Head full, retire, skid empty, accept: input loads head. Throughput is 1 per cycle.
  - Head full, retire, skid full: skid moves to head and skid empties. No accept is possible because in_ready=0.
  - Retire, no accept, skid empty: head valid clears.
- Latency: an accepted instruction appears on out_* the next cycle when the head is empty or retiring.
- Flush (priority below reset): both valids clear at the edge. An input presented in the same cycle is dropped. in_ready=1 the next cycle. A retire coinciding with flush still counts as retired for MEM; the stage just clears.
- Data registers hold their value when not loaded. Control bits of invalid entries are don't-care externally but must be gated: out_regwrite/out_memread/out_memwrite read 0 when out_valid=0.
- Forwarding: fwd_valid = out_valid && out_regwrite && !out_memread && out_rd!=0. fwd_rd = out_rd, fwd_result = out_result. The skid entry is never forwarded; hazard control must stall when the skid is valid (in_ready=0 already blocks issue).
- No combinational path from in_* to out_*, or from out_ready to in_ready.

Optional Feature:
- Macro: EX_MEM_OVF_TRAP_EN.
- Defined:
  - On accept with in_ovf && in_ovf_trap, the entry stores exc=1, and regwrite/memread/memwrite are forced 0.
  - out_exc = out_valid && exc, with out_pc carried for the EPC.
  - Subsequent accepts proceed normally; the front end flushes.
- Undefined:
  - in_ovf and in_ovf_trap are ignored, out_exc is constant 0, and the exc register is not built.

Test Plan:
- Reset, then in_valid=1, in_result=0x0000_00F0, in_rd=8, in_regwrite=1, out_ready=1 -> next cycle out_valid=1, out_result=0x0000_00F0, fwd_valid=1, fwd_rd=8; in_ready stays 1.
- out_ready=0, send A=0x11 then B=0x22 -> head=A, skid=B, in_ready=0. Raise out_ready -> A retires, then B, then out_valid=0; no loss or reorder.
- Back-to-back stream of 8 instructions with out_ready=1 -> one retire per cycle, results 1..8 in order, in_ready constant 1.
- Head and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, input not captured.
- Entry with in_rd=0, in_regwrite=1 -> fwd_valid=0. Load to rd=5 -> fwd_valid=0.
- With EX_MEM_OVF_TRAP_EN defined: in_ovf=1, in_ovf_trap=1, in_pc=0x0040_0010, in_regwrite=1 -> out_exc=1, out_pc=0x0040_0010, out_regwrite=0. With the macro undefined, the same stimulus gives out_exc=0 and out_regwrite=1.
